lcd_bus_reader: RTL
===================

Name: lcd_bus_reader

Overview:
Read-side master for the HD44780-compatible 8-bit LCD bus. It complements the existing command/data writer, which always holds rw=0.
- Performs read cycles (rw=1): status reads (rs=0, returning busy flag BF and address counter AC) and DDRAM/CGRAM data reads (rs=1).
- Optional busy-poll mode repeats status reads until BF=0, so the writer can be gated on real LCD readiness instead of fixed delays.
- Sits beside the writer; the top level muxes rs/rw/en and tri-states the writer's data drive while bus_rd=1.

Parameters:
T_AS, 3, setup cycles with rs/rw stable before en rises (≥40 ns at 50 MHz)
T_PW, 25, en-high cycles; data sampled on the last one (≥230 ns pulse, ≥160 ns data delay)
T_LO, 25, en-low cycles after the pulse, before done or the next poll (enforces ≥500 ns cycle)
MAX_POLLS, 5000, maximum status reads in busy-poll mode before timeout (1..65535)

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
req  in  1  start request; sampled only in IDLE
rd_rs  in  1  0 = status read, 1 = data read; captured on accept
wait_busy  in  1  1 = repeat status reads until BF=0; ignored when rd_rs=1; captured on accept
busy  out  1  transaction in progress
done  out  1  one-cycle completion pulse
rd_data  out  8  last byte sampled
bf  out  1  busy flag from the last status read
ac  out  7  address counter from the last status read
timeout  out  1  last transaction ended at MAX_POLLS with BF=1
lcd_rs  out  1  LCD register select
lcd_rw  out  1  LCD read/write (1 during reader ownership)
lcd_en  out  1  LCD enable strobe
lcd_dat_in  in  8  LCD data bus input
bus_rd  out  1  reader owns the bus; top level disables the writer's data drive

Behaviour:
- Reset (rst_n=0 at a clk edge): state IDLE.
  - busy, done, lcd_en, lcd_rw, lcd_rs, bus_rd, timeout, bf all 0.
  - rd_data = 8'h00, ac = 7'h00.
  - Poll counter and phase timer cleared.
  - Applies in any state. Reset mid-transaction aborts with no done pulse and drops lcd_en the following cycle.
- FSM states: IDLE, SETUP, EN_HI, EN_LO, DONE.
- IDLE: on req=1, capture rd_rs and wait_busy, clear the poll counter and timeout, and go to SETUP. The accept edge is cycle 0.
- SETUP: lasts T_AS cycles.
  - lcd_rw=1, lcd_rs=captured rd_rs, bus_rd=1, lcd_en=0.
  - Then go to EN_HI.
- EN_HI: lasts T_PW cycles with lcd_en=1.
  - On the final cycle, register lcd_dat_in into rd_data.
  - If status read: bf <= lcd_dat_in[7], ac <= lcd_dat_in[6:0], and the poll counter increments.
  - Then go to EN_LO.
- EN_LO: lasts T_LO cycles with lcd_en=0, rw/rs held, bus_rd=1. At the end:
  - Poll mode, bf=1, poll counter < MAX_POLLS: go to SETUP.
  - Poll mode, bf=1, poll counter = MAX_POLLS: set timeout=1 and go to DONE.
  - Otherwise: go to DONE.
- DONE: one cycle.
  - done=1, busy=1.
  - lcd_rw=0, lcd_rs=0, bus_rd=0.
  - Then go to IDLE.
- busy = 1 in every state except IDLE.
- Single-read latency: SETUP occupies cycles 1..T_AS, done at cycle T_AS+T_PW+T_LO+1 (54 with defaults). Each extra poll adds T_AS+T_PW+T_LO (53) cycles.
- req while busy is ignored; no queueing. req held high is accepted again in the IDLE cycle after DONE.
- Data reads leave bf and ac unchanged.
- rd_data, bf, ac and timeout hold until the next sample or clear.
- The poll counter is 16 bits and saturates; it never wraps.
- lcd_en never toggles outside EN_HI, and lcd_rw never changes while lcd_en=1.

Decomposition:
- Shared package lcd_pkg:
  - FSM state encoding.
  - HD44780 constants: BF bit index 7, AC field [6:0], instruction codes shared with the writer (8'h38, 8'h0E, 8'h01, 8'h80, 8'hC0).
- Sub-module lcd_phase_timer: loadable 16-bit down-counter with load value and a "last" flag. Used for T_AS/T_PW/T_LO timing here and reusable by the writer to replace its free-running divider.

Test Plan:
- Status read: req with rd_rs=0, wait_busy=0, lcd_dat_in=8'h25 → lcd_en high cycles 4..28 only; done at cycle 54; bf=0, ac=7'h25, rd_data=8'h25; lcd_rw=1 and bus_rd=1 from cycle 1 to 53.
- Busy poll: wait_busy=1, lcd_dat_in=8'h80 for the first 3 samples then 8'h05 → 4 en pulses; done at cycle 213; bf=0, ac=7'h05, timeout=0.
- Timeout: MAX_POLLS=4, lcd_dat_in=8'hFF constant, wait_busy=1 → exactly 4 en pulses; done with timeout=1, bf=1, ac=7'h7F.
- Data read: rd_rs=1, lcd_dat_in=8'h41, prior bf=0/ac=7'h25 → lcd_rs=1 throughout; rd_data=8'h41; bf and ac unchanged; done at 54.
- Reset and overlap: rst_n=0 at cycle 10 (in EN_HI) → cycle 11 lcd_en=0, busy=0, bus_rd=0, no done. Separately, a req pulse during EN_LO → ignored; only one done.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780 8-bit bus blocks: reader FSM encoding,
// status-byte field positions, common instruction codes and small helpers.
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_EN_HI = 3'd2,
    ST_EN_LO = 3'd3,
    ST_DONE  = 3'd4
  } rd_state_e;

  localparam int unsigned BF_BIT = 7;
  localparam int unsigned AC_MSB = 6;

  localparam logic [7:0] LCD_CMD_FUNC_SET = 8'h38;
  localparam logic [7:0] LCD_CMD_DISP_ON  = 8'h0E;
  localparam logic [7:0] LCD_CMD_CLEAR    = 8'h01;
  localparam logic [7:0] LCD_CMD_LINE1    = 8'h80;
  localparam logic [7:0] LCD_CMD_LINE2    = 8'hC0;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    logic [15:0] r;
    if (v == 16'hFFFF) begin
      r = v;
    end else begin
      r = v + 16'd1;
    end
    return r;
  endfunction

  // Phase timer load value: the timer flags "last" once it reaches zero.
  function automatic logic [15:0] phase_load(input int unsigned cycles);
    return 16'(cycles - 32'd1);
  endfunction

endpackage

// File: rtl/lcd_bus_reader_if.sv
// Host-side request/response and LCD bus signals of the read-side master.
interface lcd_bus_reader_if;
  logic       req;
  logic       rd_rs;
  logic       wait_busy;
  logic       busy;
  logic       done;
  logic [7:0] rd_data;
  logic       bf;
  logic [6:0] ac;
  logic       timeout;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_en;
  logic [7:0] lcd_dat_in;
  logic       bus_rd;

  modport master (
    input  req, rd_rs, wait_busy, lcd_dat_in,
    output busy, done, rd_data, bf, ac, timeout, lcd_rs, lcd_rw, lcd_en, bus_rd
  );

  modport slave (
    output req, rd_rs, wait_busy, lcd_dat_in,
    input  busy, done, rd_data, bf, ac, timeout, lcd_rs, lcd_rw, lcd_en, bus_rd
  );
endinterface

// File: rtl/lcd_phase_timer.sv
// Loadable 16-bit down-counter; last_o is high while the count sits at zero,
// so loading N-1 yields a phase of exactly N cycles.
module lcd_phase_timer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_i,
  input  logic [15:0] load_val_i,
  output logic        last_o
);

  logic [15:0] cnt_q;
  logic [15:0] cnt_d;

  // Next count: load has priority, otherwise count down and park at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != 16'd0) begin
      cnt_d = cnt_q - 16'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= 16'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last_o = (cnt_q == 16'd0);

endmodule

// File: rtl/lcd_bus_reader.sv
// HD44780 read-cycle master: status/data reads with optional busy polling.
// Bus outputs are registered from the next state so they align with the FSM.
module lcd_bus_reader
  import lcd_pkg::*;
#(
  parameter int unsigned T_AS      = 3,
  parameter int unsigned T_PW      = 25,
  parameter int unsigned T_LO      = 25,
  parameter int unsigned MAX_POLLS = 5000
) (
  input  logic              clk,
  input  logic              rst_n,
  lcd_bus_reader_if.master  bus
);

  rd_state_e   state_q, state_d;
  logic        rs_q, rs_d;
  logic        wb_q, wb_d;
  logic [15:0] poll_q, poll_d;
  logic        timeout_q, timeout_d;
  logic [7:0]  rd_data_q, rd_data_d;
  logic        bf_q, bf_d;
  logic [6:0]  ac_q, ac_d;

  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        en_q, en_d;
  logic        rw_q, rw_d;
  logic        lrs_q, lrs_d;
  logic        bus_rd_q, bus_rd_d;

  logic        tmr_load_s;
  logic [15:0] tmr_val_s;
  logic        tmr_last_s;

  lcd_phase_timer u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (tmr_load_s),
    .load_val_i (tmr_val_s),
    .last_o     (tmr_last_s)
  );

  // Next-state, capture and sampling logic.
  always_comb begin
    state_d    = state_q;
    rs_d       = rs_q;
    wb_d       = wb_q;
    poll_d     = poll_q;
    timeout_d  = timeout_q;
    rd_data_d  = rd_data_q;
    bf_d       = bf_q;
    ac_d       = ac_q;
    tmr_load_s = 1'b0;
    tmr_val_s  = 16'd0;

    case (state_q)
      ST_IDLE: begin
        if (bus.req) begin
          rs_d       = bus.rd_rs;
          wb_d       = bus.wait_busy & ~bus.rd_rs;
          poll_d     = 16'd0;
          timeout_d  = 1'b0;
          state_d    = ST_SETUP;
          tmr_load_s = 1'b1;
          tmr_val_s  = phase_load(T_AS);
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETUP: begin
        if (tmr_last_s) begin
          state_d    = ST_EN_HI;
          tmr_load_s = 1'b1;
          tmr_val_s  = phase_load(T_PW);
        end else begin
          state_d = ST_SETUP;
        end
      end
      ST_EN_HI: begin
        if (tmr_last_s) begin
          rd_data_d = bus.lcd_dat_in;
          if (!rs_q) begin
            bf_d   = bus.lcd_dat_in[BF_BIT];
            ac_d   = bus.lcd_dat_in[AC_MSB:0];
            poll_d = sat_inc16(poll_q);
          end else begin
            poll_d = poll_q;
          end
          state_d    = ST_EN_LO;
          tmr_load_s = 1'b1;
          tmr_val_s  = phase_load(T_LO);
        end else begin
          state_d = ST_EN_HI;
        end
      end
      ST_EN_LO: begin
        if (tmr_last_s) begin
          // bf_q already holds this poll's sample; rs_q=0 is implied by wb_q.
          if (wb_q && bf_q) begin
            if (poll_q >= 16'(MAX_POLLS)) begin
              timeout_d = 1'b1;
              state_d   = ST_DONE;
            end else begin
              state_d    = ST_SETUP;
              tmr_load_s = 1'b1;
              tmr_val_s  = phase_load(T_AS);
            end
          end else begin
            state_d = ST_DONE;
          end
        end else begin
          state_d = ST_EN_LO;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output decode from the upcoming state, registered below.
  always_comb begin
    busy_d   = (state_d != ST_IDLE);
    done_d   = (state_d == ST_DONE);
    en_d     = (state_d == ST_EN_HI);
    bus_rd_d = (state_d == ST_SETUP) || (state_d == ST_EN_HI) || (state_d == ST_EN_LO);
    rw_d     = bus_rd_d;
    lrs_d    = bus_rd_d & rs_d;
  end

  // State, captured context and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      rs_q      <= 1'b0;
      wb_q      <= 1'b0;
      poll_q    <= 16'd0;
      timeout_q <= 1'b0;
      rd_data_q <= 8'h00;
      bf_q      <= 1'b0;
      ac_q      <= 7'h00;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      en_q      <= 1'b0;
      rw_q      <= 1'b0;
      lrs_q     <= 1'b0;
      bus_rd_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      rs_q      <= rs_d;
      wb_q      <= wb_d;
      poll_q    <= poll_d;
      timeout_q <= timeout_d;
      rd_data_q <= rd_data_d;
      bf_q      <= bf_d;
      ac_q      <= ac_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      en_q      <= en_d;
      rw_q      <= rw_d;
      lrs_q     <= lrs_d;
      bus_rd_q  <= bus_rd_d;
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.rd_data = rd_data_q;
  assign bus.bf      = bf_q;
  assign bus.ac      = ac_q;
  assign bus.timeout = timeout_q;
  assign bus.lcd_rs  = lrs_q;
  assign bus.lcd_rw  = rw_q;
  assign bus.lcd_en  = en_q;
  assign bus.bus_rd  = bus_rd_q;

endmodule
